// File: rtl/dmi_stream_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmi_stream_bridge                                            |
// | Description : Byte-stream front end for the debug module interface.        |
// |               Framed commands arrive on an 8-bit valid/ready RX stream.    |
// |               The bridge issues one DMI read or write per command and      |
// |               returns read data, ACK or NAK on an 8-bit valid/ready TX     |
// |               stream.                                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Command framing: byte0[7] = write, byte0[6:0] = DMI address.               |
// |   A write is followed by 4 data bytes, LSB first. A read has no payload.   |
// | Response: a read returns 4 bytes, LSB first; a write returns ACK_BYTE.     |
// |   A timed-out access returns NAK_BYTE.                                     |
// |                                                                            |
// | Optional feature macro: DMI_BRIDGE_TIMEOUT_EN                              |
// |   Defined   : the access is abandoned after TIMEOUT_CYCLES WAIT cycles.    |
// |               oErr is a sticky timeout flag, cleared by the next command.  |
// |   Undefined : WAIT lasts until iDmAccessValid arrives; oErr is tied to 0.  |
// |                                                                            |
// | Ports:                                                                     |
// |   iClk, iRst          clock, asynchronous active-high reset                |
// |   iRxData/iRxValid/oRxReady   command byte stream in                       |
// |   oTxData/oTxValid/iTxReady   response byte stream out                     |
// |   oDmReq/oDmWrite/oDmAddr/oDmWdata   DMI request, held during access      |
// |   iDmRdata/iDmAccessValid     DMI read data and completion strobe          |
// |   oBusy                       bridge is not idle                           |
// |   oErr                        sticky timeout flag                          |
// +----------------------------------------------------------------------------+
module dmi_stream_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  NAK_BYTE       = 8'h5A
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [7:0]  iRxData,
  input  logic        iRxValid,
  output logic        oRxReady,
  output logic [7:0]  oTxData,
  output logic        oTxValid,
  input  logic        iTxReady,
  output logic        oDmReq,
  output logic        oDmWrite,
  output logic [6:0]  oDmAddr,
  output logic [31:0] oDmWdata,
  input  logic [31:0] iDmRdata,
  input  logic        iDmAccessValid,
  output logic        oBusy,
  output logic        oErr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RXDATA = 2'd1,
    S_WAIT   = 2'd2,
    S_TX     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  rx_cnt_q, rx_cnt_d;
  logic [1:0]  tx_idx_q, tx_idx_d;
  // Index of the final response byte: 3 for read data, 0 for ACK/NAK.
  logic [1:0]  tx_last_q, tx_last_d;
  logic [31:0] resp_q, resp_d;

  logic        w_rx_ready;
  logic        w_rx_fire;
  logic        w_tx_fire;
  logic        w_timeout;

  assign w_rx_ready = (state_q == S_IDLE) || (state_q == S_RXDATA);
  assign w_rx_fire  = iRxValid && w_rx_ready;
  assign w_tx_fire  = (state_q == S_TX) && iTxReady;

`ifdef DMI_BRIDGE_TIMEOUT_EN
  localparam int unsigned      c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic              err_q, err_d;

  // The counter holds the number of WAIT edges already seen, so the access
  // is abandoned on the TIMEOUT_CYCLES-th WAIT edge. A coincident strobe wins.
  assign w_timeout = (state_q == S_WAIT) && !iDmAccessValid && (to_cnt_q == c_TO_LAST);

  always_comb begin
    to_cnt_d = '0;
    err_d    = err_q;
    if (state_q == S_WAIT) begin
      to_cnt_d = to_cnt_q + c_TO_W'(1);
    end
    if (w_timeout) begin
      err_d = 1'b1;
    end else if ((state_q == S_IDLE) && w_rx_fire) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign oErr = err_q;
`else
  // No timeout path in this build; the parameter is still referenced so the
  // parameter list is identical in both builds.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign oErr      = 1'b0;
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rx_cnt_d  = rx_cnt_q;
    tx_idx_d  = tx_idx_q;
    tx_last_d = tx_last_q;
    resp_d    = resp_q;

    case (state_q)
      S_IDLE: begin
        if (w_rx_fire) begin
          write_d  = iRxData[7];
          addr_d   = iRxData[6:0];
          rx_cnt_d = 2'd0;
          state_d  = iRxData[7] ? S_RXDATA : S_WAIT;
        end
      end

      S_RXDATA: begin
        if (w_rx_fire) begin
          wdata_d[{rx_cnt_q, 3'b000} +: 8] = iRxData;
          rx_cnt_d = rx_cnt_q + 2'd1;
          if (rx_cnt_q == 2'd3) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (iDmAccessValid) begin
          tx_idx_d = 2'd0;
          if (write_q) begin
            resp_d    = {24'h0, ACK_BYTE};
            tx_last_d = 2'd0;
          end else begin
            resp_d    = iDmRdata;
            tx_last_d = 2'd3;
          end
          state_d = S_TX;
        end else if (w_timeout) begin
          resp_d    = {24'h0, NAK_BYTE};
          tx_last_d = 2'd0;
          tx_idx_d  = 2'd0;
          state_d   = S_TX;
        end
      end

      S_TX: begin
        if (w_tx_fire) begin
          if (tx_idx_q == tx_last_q) begin
            tx_idx_d = 2'd0;
            state_d  = S_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= 7'h00;
      wdata_q   <= 32'h0;
      rx_cnt_q  <= 2'd0;
      tx_idx_q  <= 2'd0;
      tx_last_q <= 2'd0;
      resp_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_idx_q  <= tx_idx_d;
      tx_last_q <= tx_last_d;
      resp_q    <= resp_d;
    end
  end

  // Outputs are decoded from registered state only, so an asynchronous reset
  // removes the request and any pending response immediately.
  assign oRxReady = w_rx_ready;
  assign oTxValid = (state_q == S_TX);
  assign oTxData  = (state_q == S_TX) ? resp_q[{tx_idx_q, 3'b000} +: 8] : 8'h00;
  assign oDmReq   = (state_q == S_WAIT);
  assign oDmWrite = write_q;
  assign oDmAddr  = addr_q;
  assign oDmWdata = wdata_q;
  assign oBusy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmi_stream_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmi_stream_bridge                                         |
// | Description : Self-checking bench for dmi_stream_bridge. A queue-based     |
// |               transaction model predicts every output each cycle; directed |
// |               scenarios pin the model with literal expectations, followed  |
// |               by a randomized traffic phase.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmi_stream_bridge;

  localparam int         TO  = 8;
  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'h5A;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [7:0]  iRxData = 8'h00;
  logic        iRxValid = 1'b0;
  logic        oRxReady;
  logic [7:0]  oTxData;
  logic        oTxValid;
  logic        iTxReady = 1'b0;
  logic        oDmReq;
  logic        oDmWrite;
  logic [6:0]  oDmAddr;
  logic [31:0] oDmWdata;
  logic [31:0] iDmRdata = 32'h0;
  logic        iDmAccessValid = 1'b0;
  logic        oBusy;
  logic        oErr;

  always #5 iClk = ~iClk;

  dmi_stream_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ACK_BYTE      (ACK),
    .NAK_BYTE      (NAK)
  ) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iRxData       (iRxData),
    .iRxValid      (iRxValid),
    .oRxReady      (oRxReady),
    .oTxData       (oTxData),
    .oTxValid      (oTxValid),
    .iTxReady      (iTxReady),
    .oDmReq        (oDmReq),
    .oDmWrite      (oDmWrite),
    .oDmAddr       (oDmAddr),
    .oDmWdata      (oDmWdata),
    .iDmRdata      (iDmRdata),
    .iDmAccessValid(iDmAccessValid),
    .oBusy         (oBusy),
    .oErr          (oErr)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model: bytes of the command being assembled, a pending DMI
  // access, and a queue of response bytes still to be sent.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_cmd[$];
  logic [7:0]  m_txq[$];
  bit          m_pend = 1'b0;
  bit          m_err = 1'b0;
  int          m_wcnt = 0;
  logic [6:0]  m_addr = 7'h0;
  bit          m_write = 1'b0;
  logic [31:0] m_wdata = 32'h0;

  initial forever begin
    @(posedge iClk or posedge iRst);
    if (iRst) begin
      m_cmd.delete();
      m_txq.delete();
      m_pend = 1'b0;
      m_err = 1'b0;
      m_wcnt = 0;
      m_addr = 7'h0;
      m_write = 1'b0;
      m_wdata = 32'h0;
    end else if (m_txq.size() != 0) begin
      if (iTxReady) void'(m_txq.pop_front());
    end else if (m_pend) begin
      if (iDmAccessValid) begin
        m_pend = 1'b0;
        if (m_write) m_txq.push_back(ACK);
        else for (int k = 0; k < 4; k++) m_txq.push_back(iDmRdata[8*k +: 8]);
      end
`ifdef DMI_BRIDGE_TIMEOUT_EN
      else begin
        m_wcnt++;
        if (m_wcnt == TO) begin
          m_pend = 1'b0;
          m_err = 1'b1;
          m_txq.push_back(NAK);
        end
      end
`endif
    end else if (iRxValid) begin
      logic [7:0] b0;
      m_cmd.push_back(iRxData);
      if (m_cmd.size() == 1) m_err = 1'b0;
      b0 = m_cmd[0];
      if (!b0[7] || m_cmd.size() == 5) begin
        m_addr  = b0[6:0];
        m_write = b0[7];
        if (b0[7]) m_wdata = {m_cmd[4], m_cmd[3], m_cmd[2], m_cmd[1]};
        m_pend = 1'b1;
        m_wcnt = 0;
        m_cmd.delete();
      end
    end
  end

  // Per-cycle comparison against the model, plus request observations.
  int          req_cycles = 0;
  logic [6:0]  seen_addr = 7'h0;
  logic        seen_write = 1'b0;
  logic [31:0] seen_wdata = 32'h0;

  initial forever begin
    @(posedge iClk);
    #1;
    chk1("rx_ready", oRxReady, (m_txq.size() == 0) && !m_pend);
    chk1("tx_valid", oTxValid, m_txq.size() != 0);
    if (m_txq.size() != 0) chk8("tx_data", oTxData, m_txq[0]);
    chk1("dm_req", oDmReq, m_pend);
    if (m_pend) begin
      chk8("dm_addr", {1'b0, oDmAddr}, {1'b0, m_addr});
      chk1("dm_write", oDmWrite, m_write);
      if (m_write) chk32("dm_wdata", oDmWdata, m_wdata);
    end
    chk1("busy", oBusy, m_pend || (m_txq.size() != 0) || (m_cmd.size() != 0));
    chk1("err", oErr, m_err);
    if (oDmReq) begin
      req_cycles++;
      seen_addr  = oDmAddr;
      seen_write = oDmWrite;
      seen_wdata = oDmWdata;
    end
  end

  // Transfer monitor: inputs and outputs are both stable at the falling edge.
  logic [7:0] tx_log[$];
  int         rx_acc = 0;

  initial forever begin
    @(negedge iClk);
    if (!iRst) begin
      if (oTxValid && iTxReady) tx_log.push_back(oTxData);
      if (iRxValid && oRxReady) rx_acc++;
    end
  end

  function automatic logic [7:0] tx_at(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 8'hxx;
  endfunction

  // Inputs change 3 time units after the rising edge.
  task automatic tick();
    @(posedge iClk);
    #3;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    bit done;
    done = 1'b0;
    iRxValid = 1'b1;
    iRxData  = b;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge iClk);
      rdy = oRxReady;
      tick();
      if (rdy) done = 1'b1;
    end
    iRxValid = 1'b0;
    if (!done) bound_fail("send_byte");
  endtask

  task automatic wait_tx(input int n, input int budget);
    int c;
    c = 0;
    while (tx_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (tx_log.size() < n) bound_fail("wait_tx");
  endtask

  task automatic pulse_valid(input logic [31:0] rdata);
    iDmRdata = rdata;
    iDmAccessValid = 1'b1;
    tick();
    iDmAccessValid = 1'b0;
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    chk1("rst_rx_ready", oRxReady, 1'b1);
    chk1("rst_tx_valid", oTxValid, 1'b0);
    chk8("rst_tx_data", oTxData, 8'h00);
    chk1("rst_dm_req", oDmReq, 1'b0);
    chk1("rst_dm_write", oDmWrite, 1'b0);
    chk8("rst_dm_addr", {1'b0, oDmAddr}, 8'h00);
    chk32("rst_dm_wdata", oDmWdata, 32'h0);
    chk1("rst_busy", oBusy, 1'b0);
    chk1("rst_err", oErr, 1'b0);
    iRst = 1'b0;
    tick();

    // Read with a three-cycle access.
    tx_log.delete();
    req_cycles = 0;
    iTxReady = 1'b1;
    send_byte(8'h11);
    tick();
    tick();
    pulse_valid(32'hDEADBEEF);
    wait_tx(4, 50);
    chk8("rd_b0", tx_at(0), 8'hEF);
    chk8("rd_b1", tx_at(1), 8'hBE);
    chk8("rd_b2", tx_at(2), 8'hAD);
    chk8("rd_b3", tx_at(3), 8'hDE);
    chk32("rd_req_cycles", req_cycles, 32'd3);
    chk8("rd_addr", {1'b0, seen_addr}, 8'h11);
    chk1("rd_write", seen_write, 1'b0);

    // Write.
    tx_log.delete();
    send_byte(8'h90);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    chk1("wr_req_early", oDmReq, 1'b0);
    send_byte(8'h12);
    chk1("wr_req_rise", oDmReq, 1'b1);
    chk8("wr_addr", {1'b0, oDmAddr}, 8'h10);
    chk1("wr_write", oDmWrite, 1'b1);
    chk32("wr_wdata", oDmWdata, 32'h12345678);
    pulse_valid(32'hFFFF_FFFF);
    wait_tx(1, 50);
    tick();
    tick();
    chk8("wr_ack", tx_at(0), 8'hA5);
    chk32("wr_tx_count", tx_log.size(), 32'd1);

    // Back-pressure on the response stream; RX must be refused meanwhile.
    tx_log.delete();
    iTxReady = 1'b0;
    send_byte(8'h22);
    pulse_valid(32'hDEADBEEF);
    begin
      int acc0;
      acc0 = rx_acc;
      iRxValid = 1'b1;
      iRxData  = 8'h33;
      for (int i = 0; i < 5; i++) begin
        chk8("bp_data", oTxData, 8'hEF);
        chk1("bp_valid", oTxValid, 1'b1);
        tick();
      end
      iRxValid = 1'b0;
      chk32("bp_no_rx", rx_acc, acc0);
    end
    iTxReady = 1'b1;
    wait_tx(4, 50);
    chk8("bp_b0", tx_at(0), 8'hEF);
    chk8("bp_b3", tx_at(3), 8'hDE);

`ifdef DMI_BRIDGE_TIMEOUT_EN
    // Timeout with no completion strobe.
    tx_log.delete();
    req_cycles = 0;
    send_byte(8'h04);
    wait_tx(1, 50);
    chk32("to_req_cycles", req_cycles, TO);
    chk1("to_err", oErr, 1'b1);
    chk8("to_nak", tx_at(0), 8'h5A);
    tick();
    send_byte(8'h01);
    chk1("to_err_clear", oErr, 1'b0);
    tx_log.delete();
    pulse_valid(32'h01020304);
    wait_tx(4, 50);
    chk8("to_next_b0", tx_at(0), 8'h04);
`else
    // Without the timeout the access waits indefinitely.
    tx_log.delete();
    send_byte(8'h04);
    repeat (300) tick();
    chk1("nto_req_held", oDmReq, 1'b1);
    chk1("nto_err", oErr, 1'b0);
    chk32("nto_no_tx", tx_log.size(), 32'd0);
    pulse_valid(32'h01020304);
    wait_tx(4, 50);
    chk8("nto_b0", tx_at(0), 8'h04);
`endif

    // Reset in the middle of a write.
    tick();
    tx_log.delete();
    send_byte(8'h85);
    send_byte(8'hAA);
    send_byte(8'hBB);
    iRst = 1'b1;
    #1;
    chk1("rst_mid_busy_async", oBusy, 1'b0);
    tick();
    iRst = 1'b0;
    tick();
    chk1("rst_mid_busy", oBusy, 1'b0);
    repeat (5) tick();
    chk32("rst_mid_no_tx", tx_log.size(), 32'd0);
    send_byte(8'h07);
    pulse_valid(32'h0BADF00D);
    wait_tx(4, 50);
    chk8("rst_rd_b0", tx_at(0), 8'h0D);
    chk8("rst_rd_b1", tx_at(1), 8'hF0);
    chk8("rst_rd_b2", tx_at(2), 8'hAD);
    chk8("rst_rd_b3", tx_at(3), 8'h0B);

    // Spurious strobe while idle.
    tick();
    tx_log.delete();
    pulse_valid(32'h55AA55AA);
    chk1("spur_busy", oBusy, 1'b0);
    chk1("spur_rx_ready", oRxReady, 1'b1);
    repeat (4) tick();
    chk32("spur_no_tx", tx_log.size(), 32'd0);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      iRst           = ($urandom_range(0, 999) < 4);
      iRxValid       = ($urandom_range(0, 99) < 50);
      iRxData        = 8'($urandom);
      iTxReady       = ($urandom_range(0, 99) < 70);
      iDmAccessValid = ($urandom_range(0, 99) < 30);
      iDmRdata       = $urandom;
      tick();
    end
    iRst = 1'b0;
    iRxValid = 1'b0;
    iDmAccessValid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
